// File: rtl/pipe_mul.sv
// pipe_mul: pipelined shift-add multiply-accumulate p = q*d + r; define PIPE_MUL_RCHK_EN to flag r >= d on rem_err
module pipe_mul #(
    parameter int QW = 8,
    parameter int DW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [QW-1:0]      q,
    input  logic [DW-1:0]      d,
    input  logic [DW-1:0]      r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [QW+DW-1:0]   p,
    output logic               rem_err
);
    localparam int PW = QW + DW;
    logic                   stall;
    logic [DW:0]            v;
    logic [DW-1:0][QW-1:0]  qs;
    logic [DW-1:0][DW-1:0]  ds;
    logic [DW:0][PW-1:0]    acc;
    logic [DW:1][PW-1:0]    nxt;
    assign stall     = v[DW] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v[DW];
    assign p         = acc[DW];
    // stage k adds q << (k-1) when multiplier bit k-1 is set
    for (genvar k = 1; k <= DW; k++) begin : g_st
        assign nxt[k] = acc[k-1] + (|(ds[k-1] & (DW'(1) << (k-1))) ? PW'(qs[k-1]) << (k-1) : PW'(0));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v   <= '0;
            qs  <= '0;
            ds  <= '0;
            acc <= '0;
        end else if (!stall) begin
            v   <= {v[DW-1:0], in_valid};
            qs  <= {qs[DW-2:0], q};
            ds  <= {ds[DW-2:0], d};
            acc <= {nxt, PW'(r)};
        end
    end
`ifdef PIPE_MUL_RCHK_EN
    logic [DW:0] re;
    assign rem_err = re[DW];
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            re <= '0;
        else if (!stall)
            re <= {re[DW-1:0], r >= d};
    end
`else
    assign rem_err = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_mul.sv
// tb_pipe_mul: directed and streaming checks of pipe_mul with a small in-order scoreboard
module tb_pipe_mul;
    localparam int QW = 8;
    localparam int DW = 4;
`ifdef PIPE_MUL_RCHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif
    typedef struct {
        logic [11:0] p;
        logic        re;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic        rem_err;
    logic [7:0]  q = '0;
    logic [3:0]  d = '0;
    logic [3:0]  r = '0;
    logic [11:0] p;
    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        sb[$];

    pipe_mul #(.QW(QW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .q(q), .d(d), .r(r), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .rem_err(rem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] qq, input logic [3:0] dd, input logic [3:0] rr);
        in_valid = 1'b1;
        q = qq;
        d = dd;
        r = rr;
    endtask

    // rt=1 feeds divider round-trip operands, rt=0 random operands
    task automatic stream(input int n, input bit rt);
        int   first = -1;
        int   last = -1;
        int   cnt = 0;
        exp_t e;
        for (int i = 0; i < n + DW + 2; i++) begin
            if (i < n) begin
                logic [7:0] a, qq;
                logic [3:0] b, dd, rr;
                if (rt) begin
                    a  = 8'($urandom_range(0, 255));
                    b  = 4'($urandom_range(1, 15));
                    qq = a / 8'(b);
                    rr = 4'(a % 8'(b));
                    dd = b;
                    sb.push_back('{12'(a), 1'b0});
                end else begin
                    qq = 8'($urandom);
                    dd = 4'($urandom);
                    rr = 4'($urandom);
                    sb.push_back('{12'(qq) * 12'(dd) + 12'(rr), RCHK && (rr >= dd)});
                end
                drive(qq, dd, rr);
            end else
                in_valid = 1'b0;
            tick;
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
                if (sb.size() == 0)
                    chk("stream_extra", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk(rt ? "rt_p" : "stream_p", 32'(p), 32'(e.p));
                    chk(rt ? "rt_rem_err" : "stream_rem_err", 32'(rem_err), 32'(e.re));
                end
            end
        end
        chk("stream_cnt", cnt, n);
        chk("stream_lat", first, DW);
        chk("stream_run", last - first + 1, n);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_p", 32'(p), 0);
        chk("rst_rem_err", 32'(rem_err), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        drive(28, 9, 3);
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        chk("basic_early", 32'(out_valid), 0);
        tick;
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_p", 32'(p), 255);
        chk("basic_rem_err", 32'(rem_err), 0);
        tick;
        chk("basic_after", 32'(out_valid), 0);

        drive(255, 15, 14);
        tick;
        drive(200, 0, 5);
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        chk("max_valid", 32'(out_valid), 1);
        chk("max_p", 32'(p), 3839);
        chk("max_rem_err", 32'(rem_err), 0);
        tick;
        chk("d0_valid", 32'(out_valid), 1);
        chk("d0_p", 32'(p), 5);
        chk("d0_rem_err", 32'(rem_err), 32'(RCHK));
        tick;
        chk("max_after", 32'(out_valid), 0);

        stream(20, 1'b0);

        drive(17, 6, 2);
        tick;
        drive(99, 11, 10);
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        chk("bp_first_valid", 32'(out_valid), 1);
        chk("bp_first_p", 32'(p), 104);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", 32'(in_ready), 0);
        repeat (3) begin
            tick;
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_p", 32'(p), 104);
            chk("bp_hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 1);
        tick;
        chk("bp_second_valid", 32'(out_valid), 1);
        chk("bp_second_p", 32'(p), 1099);
        tick;
        chk("bp_after", 32'(out_valid), 0);

        drive(10, 3, 1);
        tick;
        drive(20, 2, 0);
        tick;
        drive(5, 5, 5);
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("mid_pre_valid", 32'(out_valid), 1);
        chk("mid_pre_p", 32'(p), 31);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_p", 32'(p), 0);
        chk("mid_rst_rem_err", 32'(rem_err), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        tick;
        rst = 1'b0;
        repeat (6) begin
            tick;
            chk("mid_stale", 32'(out_valid), 0);
        end
        drive(7, 5, 4);
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        chk("mid_new_early", 32'(out_valid), 0);
        tick;
        chk("mid_new_valid", 32'(out_valid), 1);
        chk("mid_new_p", 32'(p), 39);

        stream(8, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
